maxmin_window_ctrl: RTL and testbench

MAXMIN_WINDOW_CTRL -- requirements
Module: maxmin_window_ctrl

---
 rtl/maxmin_window_ctrl.sv | 257 +++++++++++++++++++++++++
 tb/tb_maxmin_window_ctrl.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/maxmin_window_ctrl.sv
// maxmin_window_ctrl
// Second-stage decimator. Per-lane maxima and minima from stage 1 are folded
// over a window of N beats. Each closed window goes into a 2-entry result
// FIFO. A window that closes while the FIFO is full and not popping is
// dropped and counted.
module maxmin_window_ctrl #(
   parameter int LANES = 4,
   parameter int CNT_W = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [31:0]          cfg_n,
   input  logic                 cfg_load,
   input  logic                 run,
   input  logic                 beat_valid,
   input  logic [8*LANES-1:0]   s1_max,
   input  logic [8*LANES-1:0]   s1_min,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [8*LANES-1:0]   out_max,
   output logic [8*LANES-1:0]   out_min,
   output logic                 win_done,
   output logic                 ovf,
   output logic [CNT_W-1:0]     drop_cnt,
   output logic                 busy
);

   localparam int W = 8 * LANES;

   typedef enum logic {
      IDLE = 1'b0,
      ACQ  = 1'b1
   } state_t;

   state_t           state;
   logic [31:0]      n_lat;
   logic [31:0]      beat_cnt;
   logic [W-1:0]     acc_max;
   logic [W-1:0]     acc_min;
   logic [W-1:0]     tail_max;
   logic [W-1:0]     tail_min;
   logic [1:0]       count;

   logic [31:0]      n_sel;
   logic [31:0]      n_eff;
   logic [31:0]      cnt_cur;
   logic             accept;
   logic             close;
   logic             pop;
   logic             drop;
   logic [W-1:0]     res_max;
   logic [W-1:0]     res_min;
   logic [1:0]       count_nxt;
   logic [CNT_W-1:0] drop_base;
   logic             ovf_base;

   // Per-lane unsigned maximum of two packed vectors.
   function automatic logic [W-1:0] vec_max(input logic [W-1:0] a, input logic [W-1:0] b);
      logic [W-1:0] r;
      r = {W{1'b0}};
      for (int k = 0; k < LANES; k++) begin
         r[8*k +: 8] = (a[8*k +: 8] > b[8*k +: 8]) ? a[8*k +: 8] : b[8*k +: 8];
      end
      return r;
   endfunction

   // Per-lane unsigned minimum of two packed vectors.
   function automatic logic [W-1:0] vec_min(input logic [W-1:0] a, input logic [W-1:0] b);
      logic [W-1:0] r;
      r = {W{1'b0}};
      for (int k = 0; k < LANES; k++) begin
         r[8*k +: 8] = (a[8*k +: 8] < b[8*k +: 8]) ? a[8*k +: 8] : b[8*k +: 8];
      end
      return r;
   endfunction

   // Window bookkeeping, closing detection, the combined result, and the FIFO occupancy update.
   always_comb begin
      // A cfg_load in the same cycle restarts the window with the new length.
      n_sel   = cfg_load ? cfg_n : n_lat;
      n_eff   = (n_sel == 32'd0) ? 32'd1 : n_sel;
      cnt_cur = cfg_load ? 32'd0 : beat_cnt;
      accept  = (state == ACQ) && beat_valid;
      close   = accept && (cnt_cur == (n_eff - 32'd1));
      if (cnt_cur == 32'd0) begin
         res_max = s1_max;
         res_min = s1_min;
      end else begin
         res_max = vec_max(acc_max, s1_max);
         res_min = vec_min(acc_min, s1_min);
      end
      pop  = out_valid && out_ready;
      drop = close && (count == 2'd2) && !pop;
      case (count)
         2'd0: begin
            if (close) begin
               count_nxt = 2'd1;
            end else begin
               count_nxt = 2'd0;
            end
         end
         2'd1: begin
            if (close && !pop) begin
               count_nxt = 2'd2;
            end else if (pop && !close) begin
               count_nxt = 2'd0;
            end else begin
               count_nxt = 2'd1;
            end
         end
         2'd2: begin
            if (pop && !close) begin
               count_nxt = 2'd1;
            end else begin
               count_nxt = 2'd2;
            end
         end
         default: count_nxt = 2'd0;
      endcase
      // cfg_load clears the status first. A drop in the same cycle then counts against the new configuration.
      if (cfg_load) begin
         drop_base = {CNT_W{1'b0}};
         ovf_base  = 1'b0;
      end else begin
         drop_base = drop_cnt;
         ovf_base  = ovf;
      end
   end

   // Run/idle state machine with the busy flag registered alongside it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         busy  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (run) begin
                  state <= ACQ;
                  busy  <= 1'b1;
               end else begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
            end
            ACQ: begin
               if (!run) begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end else begin
                  state <= ACQ;
                  busy  <= 1'b1;
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

   // Window length latch, beat counter and running accumulators.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         n_lat    <= 32'd1;
         beat_cnt <= 32'd0;
         acc_max  <= {W{1'b0}};
         acc_min  <= {W{1'b0}};
      end else begin
         if (cfg_load) begin
            n_lat <= cfg_n;
         end
         if (accept) begin
            acc_max <= res_max;
            acc_min <= res_min;
            // Leaving ACQ discards the partial window. A window closing on that same cycle is still pushed.
            if (close || !run) begin
               beat_cnt <= 32'd0;
            end else begin
               beat_cnt <= cnt_cur + 32'd1;
            end
         end else if (cfg_load || ((state == ACQ) && !run)) begin
            beat_cnt <= 32'd0;
         end
      end
   end

   // Two-entry result FIFO; the head entry drives out_max/out_min directly.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_max   <= {W{1'b0}};
         out_min   <= {W{1'b0}};
         tail_max  <= {W{1'b0}};
         tail_min  <= {W{1'b0}};
         count     <= 2'd0;
         out_valid <= 1'b0;
      end else begin
         case (count)
            2'd0: begin
               if (close) begin
                  out_max <= res_max;
                  out_min <= res_min;
               end
            end
            2'd1: begin
               if (close && pop) begin
                  out_max <= res_max;
                  out_min <= res_min;
               end else if (close) begin
                  tail_max <= res_max;
                  tail_min <= res_min;
               end
            end
            2'd2: begin
               if (pop) begin
                  out_max <= tail_max;
                  out_min <= tail_min;
                  if (close) begin
                     tail_max <= res_max;
                     tail_min <= res_min;
                  end
               end
            end
            default: begin
               out_max <= out_max;
               out_min <= out_min;
            end
         endcase
         count     <= count_nxt;
         out_valid <= (count_nxt != 2'd0);
      end
   end

   // Window-closed pulse, sticky overflow flag and saturating drop counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         win_done <= 1'b0;
         ovf      <= 1'b0;
         drop_cnt <= {CNT_W{1'b0}};
      end else begin
         win_done <= close;
         if (drop) begin
            ovf <= 1'b1;
            if (drop_base == {CNT_W{1'b1}}) begin
               drop_cnt <= drop_base;
            end else begin
               drop_cnt <= drop_base + {{(CNT_W-1){1'b0}}, 1'b1};
            end
         end else begin
            ovf      <= ovf_base;
            drop_cnt <= drop_base;
         end
      end
   end

endmodule

// File: tb/tb_maxmin_window_ctrl.sv
// Testbench for maxmin_window_ctrl. It uses table vectors, directed corner
// sequences and random traffic. All three are compared against a
// queue-based transaction model.
module tb_maxmin_window_ctrl;

   localparam int L  = 4;
   localparam int CW = 4;
   localparam int W  = 8 * L;
   localparam int DROP_SAT = (1 << CW) - 1;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [31:0]   cfg_n;
   logic          cfg_load;
   logic          run;
   logic          beat_valid;
   logic [W-1:0]  s1_max;
   logic [W-1:0]  s1_min;
   logic          out_valid;
   logic          out_ready;
   logic [W-1:0]  out_max;
   logic [W-1:0]  out_min;
   logic          win_done;
   logic          ovf;
   logic [CW-1:0] drop_cnt;
   logic          busy;

   int checks   = 0;
   int failures = 0;

   maxmin_window_ctrl #(.LANES(L), .CNT_W(CW)) dut (
      .clk(clk), .rst_n(rst_n), .cfg_n(cfg_n), .cfg_load(cfg_load), .run(run),
      .beat_valid(beat_valid), .s1_max(s1_max), .s1_min(s1_min),
      .out_valid(out_valid), .out_ready(out_ready), .out_max(out_max), .out_min(out_min),
      .win_done(win_done), .ovf(ovf), .drop_cnt(drop_cnt), .busy(busy)
   );

   // Free-running clock.
   always #5 clk = ~clk;

   // Reference model state: beats of the open window, result FIFO contents, status.
   bit           m_acq;
   longint       m_n;
   logic [W-1:0] win_max[$];
   logic [W-1:0] win_min[$];
   logic [W-1:0] q_max[$];
   logic [W-1:0] q_min[$];
   bit           m_wd;
   bit           m_ovf;
   int           m_drop;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   function automatic logic [W-1:0] lane_fold(input logic [W-1:0] a, input logic [W-1:0] b, input bit is_max);
      logic [W-1:0] r;
      int x, y;
      r = '0;
      for (int k = 0; k < L; k++) begin
         x = int'(a[8*k +: 8]);
         y = int'(b[8*k +: 8]);
         if (is_max) r[8*k +: 8] = 8'((x > y) ? x : y);
         else        r[8*k +: 8] = 8'((x < y) ? x : y);
      end
      return r;
   endfunction

   task automatic model_reset();
      m_acq = 1'b0; m_n = 1; m_wd = 1'b0; m_ovf = 1'b0; m_drop = 0;
      win_max.delete(); win_min.delete(); q_max.delete(); q_min.delete();
   endtask

   // Advance the model by one clock using the inputs currently driven.
   task automatic model_step();
      bit           pop;
      bit           close;
      longint       neff;
      logic [W-1:0] rmax, rmin;
      pop   = (q_max.size() != 0) && out_ready;
      close = 1'b0;
      rmax  = '0;
      rmin  = '0;
      if (cfg_load) begin
         m_n = longint'(cfg_n);
         win_max.delete(); win_min.delete();
         m_ovf = 1'b0; m_drop = 0;
      end
      if (m_acq && beat_valid) begin
         win_max.push_back(s1_max);
         win_min.push_back(s1_min);
         neff = (m_n == 0) ? 1 : m_n;
         if (longint'(win_max.size()) == neff) begin
            rmax = win_max[0];
            rmin = win_min[0];
            foreach (win_max[i]) begin
               rmax = lane_fold(rmax, win_max[i], 1'b1);
               rmin = lane_fold(rmin, win_min[i], 1'b0);
            end
            close = 1'b1;
            win_max.delete(); win_min.delete();
         end
      end
      if (m_acq && !run) begin
         win_max.delete(); win_min.delete();
      end
      if (pop) begin
         void'(q_max.pop_front());
         void'(q_min.pop_front());
      end
      if (close) begin
         if (q_max.size() < 2) begin
            q_max.push_back(rmax);
            q_min.push_back(rmin);
         end else begin
            m_ovf = 1'b1;
            if (m_drop < DROP_SAT) m_drop++;
         end
      end
      m_wd  = close;
      m_acq = run;
   endtask

   // One clock: update the model, take the edge, then compare 1 time unit later.
   task automatic step();
      model_step();
      @(posedge clk);
      #1;
      chk("busy", 64'(busy), 64'(m_acq));
      chk("out_valid", 64'(out_valid), 64'(q_max.size() != 0));
      chk("win_done", 64'(win_done), 64'(m_wd));
      chk("ovf", 64'(ovf), 64'(m_ovf));
      chk("drop_cnt", 64'(drop_cnt), 64'(m_drop));
      if (q_max.size() != 0) begin
         chk("out_max", 64'(out_max), 64'(q_max[0]));
         chk("out_min", 64'(out_min), 64'(q_min[0]));
      end
   endtask

   task automatic idle_inputs();
      cfg_load = 1'b0; beat_valid = 1'b0;
   endtask

   task automatic beat(input logic [W-1:0] mx, input logic [W-1:0] mn);
      cfg_load = 1'b0; beat_valid = 1'b1; s1_max = mx; s1_min = mn;
      step();
   endtask

   task automatic load(input logic [31:0] n, input logic rdy);
      cfg_load = 1'b1; cfg_n = n; beat_valid = 1'b0; out_ready = rdy;
      step();
      cfg_load = 1'b0;
   endtask

   typedef struct {
      logic        cl;
      logic [31:0] n;
      logic        rn;
      logic        bv;
      logic [7:0]  mx;
      logic [7:0]  mn;
      logic        rdy;
      logic        e_busy;
      logic        e_ov;
      logic [7:0]  e_mx;
      logic [7:0]  e_mn;
      logic        e_wd;
   } vec_t;

   vec_t tbl[7];

   logic [W-1:0] bmx[20];
   logic [W-1:0] bmn[20];
   int           wd_cnt;

   initial begin
      // Table: four-beat window on lane 0 (max 10,50,30,20 / min 9,3,7,8).
      tbl[0] = '{1'b1, 32'd4, 1'b1, 1'b0, 8'd0,  8'd0, 1'b1, 1'b1, 1'b0, 8'd0,  8'd0, 1'b0};
      tbl[1] = '{1'b0, 32'd4, 1'b1, 1'b1, 8'd10, 8'd9, 1'b1, 1'b1, 1'b0, 8'd0,  8'd0, 1'b0};
      tbl[2] = '{1'b0, 32'd4, 1'b1, 1'b1, 8'd50, 8'd3, 1'b1, 1'b1, 1'b0, 8'd0,  8'd0, 1'b0};
      tbl[3] = '{1'b0, 32'd4, 1'b1, 1'b1, 8'd30, 8'd7, 1'b1, 1'b1, 1'b0, 8'd0,  8'd0, 1'b0};
      tbl[4] = '{1'b0, 32'd4, 1'b1, 1'b1, 8'd20, 8'd8, 1'b1, 1'b1, 1'b1, 8'd50, 8'd3, 1'b1};
      tbl[5] = '{1'b0, 32'd4, 1'b1, 1'b0, 8'd0,  8'd0, 1'b1, 1'b1, 1'b0, 8'd0,  8'd0, 1'b0};
      tbl[6] = '{1'b0, 32'd4, 1'b1, 1'b0, 8'd0,  8'd0, 1'b1, 1'b1, 1'b0, 8'd0,  8'd0, 1'b0};

      rst_n = 1'b0; cfg_n = 32'd0; cfg_load = 1'b0; run = 1'b0; beat_valid = 1'b0;
      s1_max = '0; s1_min = '0; out_ready = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_out_max", 64'(out_max), 64'd0);
      chk("rst_out_min", 64'(out_min), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_ovf", 64'(ovf), 64'd0);
      chk("rst_drop_cnt", 64'(drop_cnt), 64'd0);
      chk("rst_win_done", 64'(win_done), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Table-driven basic window.
      for (int i = 0; i < 7; i++) begin
         cfg_load = tbl[i].cl; cfg_n = tbl[i].n; run = tbl[i].rn; beat_valid = tbl[i].bv;
         s1_max = {24'h000000, tbl[i].mx}; s1_min = {24'h000000, tbl[i].mn}; out_ready = tbl[i].rdy;
         step();
         chk($sformatf("tbl%0d_busy", i), 64'(busy), 64'(tbl[i].e_busy));
         chk($sformatf("tbl%0d_out_valid", i), 64'(out_valid), 64'(tbl[i].e_ov));
         chk($sformatf("tbl%0d_win_done", i), 64'(win_done), 64'(tbl[i].e_wd));
         chk($sformatf("tbl%0d_ovf", i), 64'(ovf), 64'd0);
         if (tbl[i].e_ov) begin
            chk($sformatf("tbl%0d_max0", i), 64'(out_max[7:0]), 64'(tbl[i].e_mx));
            chk($sformatf("tbl%0d_min0", i), 64'(out_min[7:0]), 64'(tbl[i].e_mn));
         end
      end

      // cfg_n=0 behaves as a one-beat window.
      load(32'd0, 1'b1);
      wd_cnt = 0;
      for (int i = 0; i < 3; i++) begin
         bmx[i] = $urandom; bmn[i] = $urandom;
         beat(bmx[i], bmn[i]);
         wd_cnt += int'(win_done);
         chk("n0_result_max", 64'(out_max), 64'(bmx[i]));
         chk("n0_result_min", 64'(out_min), 64'(bmn[i]));
      end
      idle_inputs();
      repeat (2) begin
         step();
         wd_cnt += int'(win_done);
      end
      chk("n0_win_done_pulses", 64'(wd_cnt), 64'd3);

      // Back-pressure: 5 one-beat windows with out_ready=0 leave 2 stored and 3 dropped.
      load(32'd1, 1'b0);
      for (int i = 0; i < 5; i++) begin
         bmx[i] = $urandom; bmn[i] = $urandom;
         beat(bmx[i], bmn[i]);
      end
      idle_inputs();
      step();
      chk("bp_out_valid", 64'(out_valid), 64'd1);
      chk("bp_head_held", 64'(out_max), 64'(bmx[0]));
      chk("bp_ovf", 64'(ovf), 64'd1);
      chk("bp_drop_cnt", 64'(drop_cnt), 64'd3);
      out_ready = 1'b1;
      step();
      chk("bp_second_max", 64'(out_max), 64'(bmx[1]));
      chk("bp_second_min", 64'(out_min), 64'(bmn[1]));
      step();
      chk("bp_drained", 64'(out_valid), 64'd0);

      // A cfg_load mid-window restarts the window; its own beat is the first of the new window.
      load(32'd4, 1'b1);
      for (int i = 0; i < 3; i++) beat($urandom, $urandom);
      bmx[0] = $urandom; bmn[0] = $urandom; bmx[1] = $urandom; bmn[1] = $urandom;
      cfg_load = 1'b1; cfg_n = 32'd2; beat_valid = 1'b1; s1_max = bmx[0]; s1_min = bmn[0];
      step();
      chk("reload_no_result", 64'(out_valid), 64'd0);
      beat(bmx[1], bmn[1]);
      chk("reload_max", 64'(out_max), 64'(lane_fold(bmx[0], bmx[1], 1'b1)));
      chk("reload_min", 64'(out_min), 64'(lane_fold(bmn[0], bmn[1], 1'b0)));
      idle_inputs();
      step();

      // FIFO full, but the closing cycle also pops: no drop.
      load(32'd1, 1'b0);
      beat($urandom, $urandom);
      beat($urandom, $urandom);
      out_ready = 1'b1;
      beat($urandom, $urandom);
      chk("full_pop_ovf", 64'(ovf), 64'd0);
      chk("full_pop_drop", 64'(drop_cnt), 64'd0);
      idle_inputs();
      repeat (3) step();

      // Drop counter saturation; a later cfg_load clears the status but keeps the FIFO.
      load(32'd1, 1'b0);
      for (int i = 0; i < 20; i++) beat($urandom, $urandom);
      chk("sat_drop_cnt", 64'(drop_cnt), 64'(DROP_SAT));
      load(32'd1, 1'b0);
      chk("clr_ovf", 64'(ovf), 64'd0);
      chk("clr_drop_cnt", 64'(drop_cnt), 64'd0);
      chk("clr_keeps_fifo", 64'(out_valid), 64'd1);

      // Asynchronous reset mid-window with a full FIFO and a drop recorded.
      load(32'd2, 1'b0);
      for (int i = 0; i < 7; i++) beat($urandom, $urandom);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_out_valid", 64'(out_valid), 64'd0);
      chk("arst_out_max", 64'(out_max), 64'd0);
      chk("arst_out_min", 64'(out_min), 64'd0);
      chk("arst_busy", 64'(busy), 64'd0);
      chk("arst_ovf", 64'(ovf), 64'd0);
      chk("arst_drop_cnt", 64'(drop_cnt), 64'd0);
      chk("arst_win_done", 64'(win_done), 64'd0);
      run = 1'b0; idle_inputs(); out_ready = 1'b1;
      #3;
      rst_n = 1'b1;
      model_reset();
      step();
      chk("post_rst_no_stale", 64'(out_valid), 64'd0);
      run = 1'b1;
      step();
      for (int i = 0; i < 3; i++) beat($urandom, $urandom);
      idle_inputs();
      step();

      // Random traffic against the model.
      for (int i = 0; i < 3000; i++) begin
         cfg_load   = ($urandom_range(0, 49) == 0);
         cfg_n      = 32'($urandom_range(0, 5));
         run        = ($urandom_range(0, 15) != 0);
         beat_valid = ($urandom_range(0, 3) != 0);
         out_ready  = ($urandom_range(0, 1) == 1);
         s1_max     = $urandom;
         s1_min     = $urandom;
         step();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
